fifo_wr_push: RTL and testbench

Write-side push controller for the asynchronous FIFO, sitting between an upstream valid/ready producer and the FIFO write port.
- Buffers producer data in a 2-entry skid buffer and drives `winc`/`wdata`, throttled by the registered `wfull` from the write-pointer/full logic.
- Synchronizes the read-domain gray pointer into `wclk` and supplies it as `wq2_rptr`.
- Optionally computes a registered fill level and almost-full flag.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/sync_r2w.sv | 27 ++
 rtl/fifo_wr_push.sv | 125 ++++++++++++
 tb/tb_fifo_wr_push.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: gray/binary conversion, skid-buffer state, depth helper.
// Conversions work on a 32-bit container; narrower pointers are zero-extended
// and the result is cast back, which is exact because leading zeros do not
// change the lower bits of either conversion.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2 steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s << 1) b = b ^ (b >> s);
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer bringing a gray pointer into the write clock domain.
module sync_r2w #(
  parameter int W = 5
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_wr_push.sv
// Write-side push controller: 2-entry skid buffer feeding the FIFO write port,
// rptr synchronizer, and optional registered fill level / almost-full.
// Optional feature macro: FIFO_WR_PUSH_LEVEL_EN (level + almost-full logic).
module fifo_wr_push
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int DATASIZE     = 8,
  parameter int AFULL_THRESH = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATASIZE-1:0] s_data,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   rptr,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full
);

  localparam int PW = ADDRSIZE + 1;

  skid_state_e         state_q, state_d;
  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] skid_q, skid_d;
  logic                ready_q, ready_d;
  logic                accept, pop;

  // Handshakes: pop depends only on registered state and wfull.
  assign accept = s_valid & ready_q;
  assign pop    = (state_q != EMPTY) & ~wfull;

  assign s_ready = ready_q;
  assign winc    = pop;
  assign wdata   = head_q;

  // Skid-buffer next state; head always holds the oldest word.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        head_d  = s_data;
      end
      ONE: begin
        if (accept && !pop) begin
          state_d = TWO;
          skid_d  = s_data;
        end else if (!accept && pop) begin
          state_d = EMPTY;
        end else if (accept && pop) begin
          head_d = s_data;
        end
      end
      TWO: if (pop) begin
        state_d = ONE;
        head_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d != TWO);
  end

  // Skid-buffer registers; reset discards any buffered words.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  sync_r2w #(.W(PW)) u_sync_r2w (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d_i    (rptr),
    .q_o    (wq2_rptr)
  );

`ifdef FIFO_WR_PUSH_LEVEL_EN
  localparam int DEPTH = depth_of(ADDRSIZE);

  logic [ADDRSIZE:0] wbin, rbin, level_d, level_q;
  logic              afull_d, afull_q;

  // Modulo-2^PW subtraction stays correct across pointer wrap.
  always_comb begin
    wbin    = PW'(gray2bin(32'(wptr)));
    rbin    = PW'(gray2bin(32'(wq2_rptr)));
    level_d = wbin - rbin;
    afull_d = (level_d >= PW'(DEPTH - AFULL_THRESH));
  end

  // Registered level and almost-full flag.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign wlevel       = level_q;
  assign walmost_full = afull_q;
`else
  assign wlevel       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_push.sv
// Self-checking bench for fifo_wr_push: directed scenarios plus a random
// stream, checked against a queue-based reference of the skid buffer.
module tb_fifo_wr_push;

  logic       wclk, wrst_n;
  logic       s_valid, s_ready;
  logic [7:0] s_data;
  logic       wfull;
  logic [4:0] wptr, rptr;
  logic       winc;
  logic [7:0] wdata;
  logic [4:0] wq2_rptr, wlevel;
  logic       walmost_full;

  fifo_wr_push #(.ADDRSIZE(4), .DATASIZE(8), .AFULL_THRESH(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .wfull(wfull), .wptr(wptr), .rptr(rptr), .winc(winc),
    .wdata(wdata), .wq2_rptr(wq2_rptr), .wlevel(wlevel),
    .walmost_full(walmost_full)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // Reference: words held by the buffer, in order; ready is "fewer than 2 held".
  logic [7:0] mq[$];
  logic       mready;
  logic [7:0] acc_log[$];
  logic [7:0] dut_wr[$];

  function automatic logic [4:0] g(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the edge, check mid-cycle, advance the model at the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic f);
    logic acc, p;
    s_valid = v; s_data = d; wfull = f;
    #4;
    chk("s_ready", s_ready, mready);
    chk("winc", winc, (mq.size() > 0) && !f);
    if (mq.size() > 0) chk("wdata", wdata, mq[0]);
    if (winc === 1'b1) dut_wr.push_back(wdata);
    @(posedge wclk);
    acc = v && mready;
    p   = (mq.size() > 0) && !f;
    if (p) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(d);
      acc_log.push_back(d);
    end
    mready = (mq.size() < 2);
    #1;
  endtask

  task automatic lvl_check(input string tag, input int w, input int r);
    int lev;
    logic af;
`ifdef FIFO_WR_PUSH_LEVEL_EN
    lev = (w - r) & 31;
    af  = (lev >= 16 - 2);
`else
    lev = 0;
    af  = 1'b0;
`endif
    chk({tag, "_wlevel"}, wlevel, lev);
    chk({tag, "_afull"}, walmost_full, af);
  endtask

  // Apply new pointers, then check synchronizer latency and level latency.
  task automatic lvl(input string tag, input int w, input int r);
    wptr = g(w); rptr = g(r);
    cyc(0, 8'h00, 1'b0);
    cyc(0, 8'h00, 1'b0);
    chk({tag, "_wq2"}, wq2_rptr, g(r));
    cyc(0, 8'h00, 1'b0);
    lvl_check(tag, w, r);
  endtask

  initial begin
    int base;
    wrst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; wfull = 1'b0;
    wptr = '0; rptr = '0;
    mready = 1'b1;
    #12;
    chk("rst_s_ready", s_ready, 1); chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 0);     chk("rst_wq2", wq2_rptr, 0);
    chk("rst_wlevel", wlevel, 0);   chk("rst_afull", walmost_full, 0);
    wrst_n = 1'b1;
    @(posedge wclk); #1;

    // Streaming: 5 back-to-back words.
    base = dut_wr.size();
    for (int i = 0; i < 5; i++) cyc(1, 8'hA0 + 8'(i), 1'b0);
    cyc(0, 8'h00, 1'b0);
    chk("stream_count", dut_wr.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (dut_wr.size() > base + i) chk("stream_data", dut_wr[base + i], 8'hA0 + 8'(i));

    // Backpressure: only two words absorbed while full.
    base = acc_log.size();
    cyc(1, 8'h10, 1'b1);
    cyc(1, 8'h11, 1'b1);
    cyc(1, 8'h12, 1'b1);
    cyc(1, 8'h12, 1'b1);
    chk("bp_ready_low", s_ready, 0);
    chk("bp_accepted", acc_log.size() - base, 2);
    cyc(1, 8'h12, 1'b0);
    cyc(1, 8'h12, 1'b0);
    chk("bp_third_acc", acc_log.size() - base, 3);
    cyc(0, 8'h00, 1'b0);
    cyc(0, 8'h00, 1'b0);

    // Level and wrap.
    lvl("lvl7", 10, 3);
    wptr = g(17);
    cyc(0, 8'h00, 1'b0);
    lvl_check("lvl14", 17, 3);
    lvl("wrap14", 2, 20);
    lvl("wrap0", 4, 4);
    lvl("full16", 16, 0);
    lvl("zero", 0, 0);

    // Reset mid-operation while in the two-word state.
    cyc(1, 8'h55, 1'b1);
    cyc(1, 8'h56, 1'b1);
    s_valid = 1'b0;
    #2 wrst_n = 1'b0;
    #1;
    chk("mrst_s_ready", s_ready, 1); chk("mrst_winc", winc, 0);
    chk("mrst_wdata", wdata, 0);     chk("mrst_wq2", wq2_rptr, 0);
    chk("mrst_wlevel", wlevel, 0);   chk("mrst_afull", walmost_full, 0);
    while (mq.size() > 0) begin
      void'(mq.pop_back());
      void'(acc_log.pop_back());
    end
    mready = 1'b1;
    #3 wrst_n = 1'b1;
    @(posedge wclk); #1;
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1'b0);

    // Random stream.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 3));
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1'b0);

    // Every accepted word written exactly once, in order.
    chk("order_count", dut_wr.size(), acc_log.size());
    for (int i = 0; i < acc_log.size(); i++)
      if (i < dut_wr.size()) chk("order_data", dut_wr[i], acc_log[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
